// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit between the core datapath and data memory.
// Issues one word-aligned, byte-strobed memory access over a req/ack
// handshake, returns lane-aligned sign/zero-extended load data, and stalls
// the core while the access is outstanding.
// Optional build macro: RISCV_LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word accesses complete immediately with an error and no memory request.
module riscv_lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic        i_lsu_req,
   input  logic        i_lsu_wr_en,
   input  logic [3:0]  i_lsu_byte_sel,
   input  logic [2:0]  i_lsu_funct3,
   input  logic [31:0] i_lsu_addr,
   input  logic [31:0] i_lsu_wr_data,
   output logic [31:0] o_lsu_rd_data,
   output logic        o_lsu_busy,
   output logic        o_lsu_done,
   output logic        o_lsu_err,
   output logic        o_dmem_req,
   output logic        o_dmem_wr_en,
   output logic [31:0] o_dmem_addr,
   output logic [3:0]  o_dmem_wstrb,
   output logic [31:0] o_dmem_wr_data,
   input  logic        i_dmem_ack,
   input  logic [31:0] i_dmem_rd_data
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   // 9-bit limit so that a count of 255 compares without wrapping
   localparam logic [8:0] TO_LIM = 9'(TIMEOUT_CYCLES);
   localparam logic       TO_EN  = (TIMEOUT_CYCLES != 0);

   state_t      r_state;
   state_t      w_next;

   logic        r_wr_en;
   logic [3:0]  r_sel;
   logic        r_zext;
   logic [1:0]  r_off;
   logic [31:0] r_addr;
   logic [3:0]  r_wstrb;
   logic [31:0] r_wdata;
   logic [31:0] r_rd_data;
   logic        r_err;
   logic [7:0]  r_cnt;

   logic [3:0]  w_sel;
   logic [1:0]  w_off;
   logic [7:0]  w_strb_shift;
   logic [31:0] w_wdata;
   logic        w_misalign;
   logic        w_trap;
   logic        w_start;
   logic        w_in_req;
   logic        w_timeout;
   logic        w_unused;

   // Lane-replicate store data so the strobed byte lanes carry the value
   function automatic logic [31:0] f_store_lanes(input logic [3:0] sel,
                                                  input logic [31:0] d);
      case (sel)
         4'b0001: f_store_lanes = {4{d[7:0]}};
         4'b0011: f_store_lanes = {2{d[15:0]}};
         default: f_store_lanes = d;
      endcase
   endfunction

   // Shift the addressed lane down and sign/zero-extend to 32 bits
   function automatic logic [31:0] f_load_extend(input logic [31:0] raw,
                                                  input logic [1:0]  off,
                                                  input logic [3:0]  sel,
                                                  input logic        zext);
      logic [31:0] w;
      w = raw >> {off, 3'b000};
      case (sel)
         4'b0001: f_load_extend = zext ? {24'd0, w[7:0]}   : {{24{w[7]}}, w[7:0]};
         4'b0011: f_load_extend = zext ? {16'd0, w[15:0]}  : {{16{w[15]}}, w[15:0]};
         default: f_load_extend = w;
      endcase
   endfunction

   // Any byte-select other than byte/half is handled as a full word
   assign w_sel = ((i_lsu_byte_sel == 4'b0001) || (i_lsu_byte_sel == 4'b0011))
                  ? i_lsu_byte_sel : 4'b1111;
   assign w_off        = i_lsu_addr[1:0];
   assign w_strb_shift = {4'b0000, w_sel} << w_off;
   assign w_wdata      = f_store_lanes(w_sel, i_lsu_wr_data);
   assign w_misalign   = ((w_sel == 4'b0011) && w_off[0]) ||
                         ((w_sel == 4'b1111) && (w_off != 2'b00));

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
   assign w_trap = w_misalign;
`else
   assign w_trap = 1'b0;
`endif

   assign w_start   = (r_state == S_IDLE) && i_lsu_req;
   assign w_in_req  = (r_state == S_REQ);
   // Ack in the same cycle takes priority over the timeout
   assign w_timeout = TO_EN && w_in_req && !i_dmem_ack &&
                      (({1'b0, r_cnt} + 9'd1) == TO_LIM);

   assign w_unused  = &{1'b0, i_lsu_funct3[1:0], w_strb_shift[7:4], w_misalign};

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (i_lsu_req) w_next = w_trap ? S_RESP : S_REQ;
         S_REQ:  if (i_dmem_ack || w_timeout) w_next = S_RESP;
         S_RESP: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // State register and wait-cycle counter
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state <= S_IDLE;
         r_cnt   <= 8'd0;
      end else begin
         r_state <= w_next;
         if (w_start)
            r_cnt <= 8'd0;
         else if (w_in_req && !i_dmem_ack && !w_timeout)
            r_cnt <= r_cnt + 8'd1;
      end
   end

   // Capture the access on start; capture the result on ack or timeout
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_wr_en   <= 1'b0;
         r_sel     <= 4'd0;
         r_zext    <= 1'b0;
         r_off     <= 2'd0;
         r_addr    <= 32'd0;
         r_wstrb   <= 4'd0;
         r_wdata   <= 32'd0;
         r_rd_data <= 32'd0;
         r_err     <= 1'b0;
      end else if (w_start) begin
         r_wr_en   <= i_lsu_wr_en;
         r_sel     <= w_sel;
         r_zext    <= i_lsu_funct3[2];
         r_off     <= w_off;
         r_addr    <= {i_lsu_addr[31:2], 2'b00};
         r_wstrb   <= i_lsu_wr_en ? w_strb_shift[3:0] : 4'b0000;
         r_wdata   <= i_lsu_wr_en ? w_wdata : 32'd0;
         r_rd_data <= 32'd0;
         r_err     <= w_trap;
      end else if (w_in_req) begin
         if (i_dmem_ack) begin
            r_rd_data <= r_wr_en ? 32'd0
                                 : f_load_extend(i_dmem_rd_data, r_off, r_sel, r_zext);
            r_err     <= 1'b0;
         end else if (w_timeout) begin
            r_rd_data <= 32'd0;
            r_err     <= 1'b1;
         end
      end
   end

   assign o_dmem_req     = w_in_req;
   assign o_dmem_wr_en   = w_in_req && r_wr_en;
   assign o_dmem_addr    = r_addr;
   assign o_dmem_wstrb   = r_wstrb;
   assign o_dmem_wr_data = r_wdata;

   assign o_lsu_done     = (r_state == S_RESP);
   assign o_lsu_err      = o_lsu_done && r_err;
   assign o_lsu_rd_data  = o_lsu_done ? r_rd_data : 32'd0;
   // Released in RESP so the core advances on the done cycle
   assign o_lsu_busy     = w_start || w_in_req;

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: self-checking bench for riscv_lsu (TIMEOUT_CYCLES=4).
module tb_riscv_lsu;

   logic        clk = 1'b0;
   logic        i_rstn;
   logic        i_lsu_req;
   logic        i_lsu_wr_en;
   logic [3:0]  i_lsu_byte_sel;
   logic [2:0]  i_lsu_funct3;
   logic [31:0] i_lsu_addr;
   logic [31:0] i_lsu_wr_data;
   logic [31:0] o_lsu_rd_data;
   logic        o_lsu_busy;
   logic        o_lsu_done;
   logic        o_lsu_err;
   logic        o_dmem_req;
   logic        o_dmem_wr_en;
   logic [31:0] o_dmem_addr;
   logic [3:0]  o_dmem_wstrb;
   logic [31:0] o_dmem_wr_data;
   logic        i_dmem_ack;
   logic [31:0] i_dmem_rd_data;

   typedef struct packed {
      logic [31:0] rd;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   riscv_lsu #(.TIMEOUT_CYCLES(4)) dut (
      .i_clk          (clk),
      .i_rstn         (i_rstn),
      .i_lsu_req      (i_lsu_req),
      .i_lsu_wr_en    (i_lsu_wr_en),
      .i_lsu_byte_sel (i_lsu_byte_sel),
      .i_lsu_funct3   (i_lsu_funct3),
      .i_lsu_addr     (i_lsu_addr),
      .i_lsu_wr_data  (i_lsu_wr_data),
      .o_lsu_rd_data  (o_lsu_rd_data),
      .o_lsu_busy     (o_lsu_busy),
      .o_lsu_done     (o_lsu_done),
      .o_lsu_err      (o_lsu_err),
      .o_dmem_req     (o_dmem_req),
      .o_dmem_wr_en   (o_dmem_wr_en),
      .o_dmem_addr    (o_dmem_addr),
      .o_dmem_wstrb   (o_dmem_wstrb),
      .o_dmem_wr_data (o_dmem_wr_data),
      .i_dmem_ack     (i_dmem_ack),
      .i_dmem_rd_data (i_dmem_rd_data)
   );

   // Present a request for one cycle; returns at the negedge after capture
   task automatic drive_req(input logic wr, input logic [3:0] sel, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd);
      @(negedge clk);
      i_lsu_req      = 1'b1;
      i_lsu_wr_en    = wr;
      i_lsu_byte_sel = sel;
      i_lsu_funct3   = f3;
      i_lsu_addr     = addr;
      i_lsu_wr_data  = wd;
      @(negedge clk);
      i_lsu_req      = 1'b0;
   endtask

   task automatic ack_now(input logic [31:0] data);
      i_dmem_ack     = 1'b1;
      i_dmem_rd_data = data;
      @(negedge clk);
      i_dmem_ack     = 1'b0;
   endtask

   // Bounded wait for the done pulse; samples 1 time unit after a negedge
   task automatic wait_done(input int max, output logic got, output logic [31:0] rd,
                            output logic err);
      got = 1'b0;
      rd  = 32'd0;
      err = 1'b0;
      for (int i = 0; i < max; i++) begin
         #1;
         if (o_lsu_done === 1'b1) begin
            got = 1'b1;
            rd  = o_lsu_rd_data;
            err = o_lsu_err;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      #1;
      checks++;
      if ({o_lsu_rd_data, o_lsu_busy, o_lsu_done, o_lsu_err, o_dmem_req, o_dmem_wr_en} !== 37'd0) begin
         errors++;
         $display("FAIL reset_lsu_outs: got rd=%h busy=%b done=%b err=%b req=%b we=%b, want all 0",
                  o_lsu_rd_data, o_lsu_busy, o_lsu_done, o_lsu_err, o_dmem_req, o_dmem_wr_en);
      end
      checks++;
      if ({o_dmem_addr, o_dmem_wstrb, o_dmem_wr_data} !== 68'd0) begin
         errors++;
         $display("FAIL reset_dmem_outs: got addr=%h strb=%b wd=%h, want all 0",
                  o_dmem_addr, o_dmem_wstrb, o_dmem_wr_data);
      end
      @(negedge clk);
      i_rstn = 1'b1;
   endtask

   task automatic test_load_word;
      logic got, err;
      logic [31:0] rd;
      exp_t e;
      drive_req(1'b0, 4'b1111, 3'b010, 32'h0000_0100, 32'd0);
      sb.push_back('{rd: 32'hDEAD_BEEF, err: 1'b0});
      #1;
      checks++;
      if (o_dmem_req !== 1'b1 || o_dmem_addr !== 32'h100 || o_dmem_wstrb !== 4'b0000 ||
          o_dmem_wr_en !== 1'b0 || o_lsu_busy !== 1'b1) begin
         errors++;
         $display("FAIL lw_issue: got req=%b addr=%h strb=%b we=%b busy=%b, want 1 00000100 0000 0 1",
                  o_dmem_req, o_dmem_addr, o_dmem_wstrb, o_dmem_wr_en, o_lsu_busy);
      end
      ack_now(32'hDEAD_BEEF);
      wait_done(1, got, rd, err);
      e = sb.pop_front();
      checks++;
      if (got !== 1'b1 || rd !== e.rd || err !== e.err) begin
         errors++;
         $display("FAIL lw_result: done=%b rd=%h err=%b, want done=1 rd=%h err=%b",
                  got, rd, err, e.rd, e.err);
      end
      checks++;
      if (o_lsu_busy !== 1'b0 || o_dmem_req !== 1'b0) begin
         errors++;
         $display("FAIL lw_resp_busy: busy=%b req=%b, want 0 0", o_lsu_busy, o_dmem_req);
      end
      @(negedge clk);
      #1;
      checks++;
      if (o_lsu_done !== 1'b0 || o_lsu_rd_data !== 32'd0) begin
         errors++;
         $display("FAIL lw_done_pulse: done=%b rd=%h, want 0 00000000", o_lsu_done, o_lsu_rd_data);
      end
   endtask

   task automatic test_load_sub;
      logic [31:0] ta_addr[7] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h101, 32'h100};
      logic [2:0]  ta_f3[7]   = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b000, 3'b010};
      logic [3:0]  ta_sel[7]  = '{4'b0001, 4'b0001, 4'b0011, 4'b0011, 4'b0001, 4'b0001, 4'b0101};
      logic [31:0] ta_mem[7]  = '{32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000,
                                  32'h1234_567F, 32'h1234_5680, 32'hCAFE_F00D};
      logic [31:0] ta_exp[7]  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF,
                                  32'h0000_007F, 32'h0000_0056, 32'hCAFE_F00D};
      logic got, err;
      logic [31:0] rd;
      exp_t e;
      for (int k = 0; k < 7; k++) begin
         drive_req(1'b0, ta_sel[k], ta_f3[k], ta_addr[k], 32'hFFFF_FFFF);
         sb.push_back('{rd: ta_exp[k], err: 1'b0});
         #1;
         checks++;
         if (o_dmem_req !== 1'b1 || o_dmem_wstrb !== 4'b0000 || o_dmem_addr !== 32'h100) begin
            errors++;
            $display("FAIL load_sub_issue[%0d]: req=%b strb=%b addr=%h, want 1 0000 00000100",
                     k, o_dmem_req, o_dmem_wstrb, o_dmem_addr);
         end
         ack_now(ta_mem[k]);
         wait_done(1, got, rd, err);
         e = sb.pop_front();
         checks++;
         if (got !== 1'b1 || rd !== e.rd || err !== e.err) begin
            errors++;
            $display("FAIL load_sub[%0d]: done=%b rd=%h err=%b, want done=1 rd=%h err=%b",
                     k, got, rd, err, e.rd, e.err);
         end
      end
   endtask

   task automatic test_store;
      logic [31:0] ts_addr[4] = '{32'h202, 32'h201, 32'h300, 32'h103};
      logic [3:0]  ts_sel[4]  = '{4'b0011, 4'b0001, 4'b1111, 4'b0001};
      logic [31:0] ts_wd[4]   = '{32'h0000_ABCD, 32'h1234_5678, 32'hCAFE_BABE, 32'h0000_00A5};
      logic [3:0]  ts_strb[4] = '{4'b1100, 4'b0010, 4'b1111, 4'b1000};
      logic [31:0] ts_lane[4] = '{32'hABCD_ABCD, 32'h7878_7878, 32'hCAFE_BABE, 32'hA5A5_A5A5};
      logic got, err;
      logic [31:0] rd;
      exp_t e;
      for (int k = 0; k < 4; k++) begin
         drive_req(1'b1, ts_sel[k], 3'b000, ts_addr[k], ts_wd[k]);
         sb.push_back('{rd: 32'd0, err: 1'b0});
         #1;
         checks++;
         if (o_dmem_req !== 1'b1 || o_dmem_wr_en !== 1'b1 || o_dmem_wstrb !== ts_strb[k] ||
             o_dmem_wr_data !== ts_lane[k] || o_dmem_addr !== {ts_addr[k][31:2], 2'b00}) begin
            errors++;
            $display("FAIL store_issue[%0d]: req=%b we=%b strb=%b wd=%h addr=%h, want 1 1 %b %h %h",
                     k, o_dmem_req, o_dmem_wr_en, o_dmem_wstrb, o_dmem_wr_data, o_dmem_addr,
                     ts_strb[k], ts_lane[k], {ts_addr[k][31:2], 2'b00});
         end
         ack_now(32'h5555_AAAA);
         wait_done(1, got, rd, err);
         e = sb.pop_front();
         checks++;
         if (got !== 1'b1 || rd !== e.rd || err !== e.err) begin
            errors++;
            $display("FAIL store_done[%0d]: done=%b rd=%h err=%b, want done=1 rd=%h err=%b",
                     k, got, rd, err, e.rd, e.err);
         end
      end
   endtask

   task automatic test_wait_states;
      logic got, err;
      logic [31:0] rd;
      exp_t e;
      drive_req(1'b1, 4'b0011, 3'b001, 32'h0000_0402, 32'h0000_1357);
      sb.push_back('{rd: 32'd0, err: 1'b0});
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (o_dmem_req !== 1'b1 || o_lsu_done !== 1'b0 || o_dmem_addr !== 32'h400 ||
             o_dmem_wstrb !== 4'b1100 || o_dmem_wr_data !== 32'h1357_1357 || o_lsu_busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_stable[%0d]: req=%b done=%b addr=%h strb=%b wd=%h busy=%b",
                     k, o_dmem_req, o_lsu_done, o_dmem_addr, o_dmem_wstrb, o_dmem_wr_data, o_lsu_busy);
         end
         if (k < 2) @(negedge clk);
      end
      ack_now(32'd0);
      wait_done(1, got, rd, err);
      e = sb.pop_front();
      checks++;
      if (got !== 1'b1 || rd !== e.rd || err !== e.err) begin
         errors++;
         $display("FAIL wait_done: done=%b rd=%h err=%b, want done=1 rd=%h err=%b",
                  got, rd, err, e.rd, e.err);
      end
   endtask

   task automatic test_timeout;
      logic got, err;
      logic [31:0] rd;
      exp_t e;
      // No ack: four REQ cycles then an error completion
      drive_req(1'b0, 4'b1111, 3'b010, 32'h0000_0100, 32'd0);
      sb.push_back('{rd: 32'd0, err: 1'b1});
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++;
         if (o_dmem_req !== 1'b1) begin
            errors++;
            $display("FAIL timeout_req_held[%0d]: req=%b, want 1", k, o_dmem_req);
         end
         @(negedge clk);
      end
      wait_done(1, got, rd, err);
      e = sb.pop_front();
      checks++;
      if (got !== 1'b1 || rd !== e.rd || err !== e.err || o_dmem_req !== 1'b0) begin
         errors++;
         $display("FAIL timeout_abort: done=%b rd=%h err=%b req=%b, want done=1 rd=%h err=%b req=0",
                  got, rd, err, o_dmem_req, e.rd, e.err);
      end
      // Ack on the last allowed cycle wins over the timeout
      drive_req(1'b0, 4'b1111, 3'b010, 32'h0000_0100, 32'd0);
      sb.push_back('{rd: 32'h5A5A_5A5A, err: 1'b0});
      for (int k = 0; k < 3; k++) @(negedge clk);
      #1;
      checks++;
      if (o_dmem_req !== 1'b1) begin
         errors++;
         $display("FAIL timeout_edge_req: req=%b, want 1", o_dmem_req);
      end
      ack_now(32'h5A5A_5A5A);
      wait_done(1, got, rd, err);
      e = sb.pop_front();
      checks++;
      if (got !== 1'b1 || rd !== e.rd || err !== e.err) begin
         errors++;
         $display("FAIL timeout_ack_wins: done=%b rd=%h err=%b, want done=1 rd=%h err=%b",
                  got, rd, err, e.rd, e.err);
      end
   endtask

   task automatic test_back_to_back;
      logic got, err;
      logic [31:0] rd;
      exp_t e;
      @(negedge clk);
      i_lsu_req = 1'b1; i_lsu_wr_en = 1'b0; i_lsu_byte_sel = 4'b1111;
      i_lsu_funct3 = 3'b010; i_lsu_addr = 32'h100;
      sb.push_back('{rd: 32'h1111_1111, err: 1'b0});
      @(negedge clk);
      i_lsu_addr = 32'h400;
      #1;
      checks++;
      if (o_dmem_addr !== 32'h100) begin
         errors++;
         $display("FAIL b2b_req_in_req_ignored: addr=%h, want 00000100", o_dmem_addr);
      end
      ack_now(32'h1111_1111);
      wait_done(1, got, rd, err);
      e = sb.pop_front();
      checks++;
      if (got !== 1'b1 || rd !== e.rd || err !== e.err || o_lsu_busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_first: done=%b rd=%h err=%b busy=%b, want done=1 rd=%h err=%b busy=0",
                  got, rd, err, o_lsu_busy, e.rd, e.err);
      end
      @(negedge clk);
      #1;
      checks++;
      if (o_dmem_req !== 1'b0 || o_lsu_busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_resp_not_captured: req=%b busy=%b, want 0 1", o_dmem_req, o_lsu_busy);
      end
      sb.push_back('{rd: 32'h2222_2222, err: 1'b0});
      @(negedge clk);
      i_lsu_req = 1'b0;
      #1;
      checks++;
      if (o_dmem_req !== 1'b1 || o_dmem_addr !== 32'h400) begin
         errors++;
         $display("FAIL b2b_second_issue: req=%b addr=%h, want 1 00000400", o_dmem_req, o_dmem_addr);
      end
      ack_now(32'h2222_2222);
      wait_done(1, got, rd, err);
      e = sb.pop_front();
      checks++;
      if (got !== 1'b1 || rd !== e.rd || err !== e.err) begin
         errors++;
         $display("FAIL b2b_second: done=%b rd=%h err=%b, want done=1 rd=%h err=%b",
                  got, rd, err, e.rd, e.err);
      end
   endtask

   task automatic test_reset_mid;
      logic got, err;
      logic [31:0] rd;
      exp_t e;
      drive_req(1'b0, 4'b1111, 3'b010, 32'h0000_0500, 32'd0);
      i_rstn = 1'b0;
      #1;
      checks++;
      if (o_dmem_req !== 1'b0 || o_lsu_busy !== 1'b0 || o_lsu_done !== 1'b0 || o_dmem_addr !== 32'd0) begin
         errors++;
         $display("FAIL rst_mid_outs: req=%b busy=%b done=%b addr=%h, want 0 0 0 00000000",
                  o_dmem_req, o_lsu_busy, o_lsu_done, o_dmem_addr);
      end
      @(negedge clk);
      i_rstn = 1'b1;
      ack_now(32'hBAD0_BAD0);
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (o_lsu_done !== 1'b0 || o_dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_late_ack[%0d]: done=%b req=%b, want 0 0", k, o_lsu_done, o_dmem_req);
         end
         @(negedge clk);
      end
      drive_req(1'b0, 4'b1111, 3'b010, 32'h0000_0600, 32'd0);
      sb.push_back('{rd: 32'h0BAD_F00D, err: 1'b0});
      ack_now(32'h0BAD_F00D);
      wait_done(1, got, rd, err);
      e = sb.pop_front();
      checks++;
      if (got !== 1'b1 || rd !== e.rd || err !== e.err) begin
         errors++;
         $display("FAIL rst_recover: done=%b rd=%h err=%b, want done=1 rd=%h err=%b",
                  got, rd, err, e.rd, e.err);
      end
   endtask

   task automatic test_misalign;
      logic got, err;
      logic [31:0] rd;
      exp_t e;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
      drive_req(1'b0, 4'b0011, 3'b001, 32'h0000_0101, 32'd0);
      sb.push_back('{rd: 32'd0, err: 1'b1});
      wait_done(1, got, rd, err);
      e = sb.pop_front();
      checks++;
      if (got !== 1'b1 || rd !== e.rd || err !== e.err || o_dmem_req !== 1'b0) begin
         errors++;
         $display("FAIL misalign_trap: done=%b rd=%h err=%b req=%b, want done=1 rd=%h err=%b req=0",
                  got, rd, err, o_dmem_req, e.rd, e.err);
      end
`else
      drive_req(1'b0, 4'b0011, 3'b001, 32'h0000_0101, 32'd0);
      sb.push_back('{rd: 32'hFFFF_BBCC, err: 1'b0});
      #1;
      checks++;
      if (o_dmem_req !== 1'b1 || o_dmem_addr !== 32'h100) begin
         errors++;
         $display("FAIL misalign_lh_issue: req=%b addr=%h, want 1 00000100", o_dmem_req, o_dmem_addr);
      end
      ack_now(32'hAABB_CCDD);
      wait_done(1, got, rd, err);
      e = sb.pop_front();
      checks++;
      if (got !== 1'b1 || rd !== e.rd || err !== e.err) begin
         errors++;
         $display("FAIL misalign_lh: done=%b rd=%h err=%b, want done=1 rd=%h err=%b",
                  got, rd, err, e.rd, e.err);
      end
      drive_req(1'b1, 4'b1111, 3'b010, 32'h0000_0101, 32'h1234_5678);
      sb.push_back('{rd: 32'd0, err: 1'b0});
      #1;
      checks++;
      if (o_dmem_wstrb !== 4'b1110 || o_dmem_wr_data !== 32'h1234_5678) begin
         errors++;
         $display("FAIL misalign_sw_strb: strb=%b wd=%h, want 1110 12345678", o_dmem_wstrb, o_dmem_wr_data);
      end
      ack_now(32'd0);
      wait_done(1, got, rd, err);
      e = sb.pop_front();
      checks++;
      if (got !== 1'b1 || rd !== e.rd || err !== e.err) begin
         errors++;
         $display("FAIL misalign_sw: done=%b rd=%h err=%b, want done=1 rd=%h err=%b",
                  got, rd, err, e.rd, e.err);
      end
`endif
   endtask

   initial begin
      i_rstn         = 1'b0;
      i_lsu_req      = 1'b0;
      i_lsu_wr_en    = 1'b0;
      i_lsu_byte_sel = 4'b0000;
      i_lsu_funct3   = 3'b000;
      i_lsu_addr     = 32'd0;
      i_lsu_wr_data  = 32'd0;
      i_dmem_ack     = 1'b0;
      i_dmem_rd_data = 32'd0;
      test_reset();
      test_load_word();
      test_load_sub();
      test_store();
      test_wait_states();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      test_misalign();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog so the run always terminates
   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end

endmodule
